// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int CNT_W_DEF = 16;

    // A producer hits a source only if it really writes a nonzero register.
    function automatic logic dest_hit(input logic [4:0] aw,
                                      input logic       we,
                                      input logic [4:0] src);
        return we && (aw != 5'd0) && (aw == src);
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating event counter: counts cycles with inc high, holds at all-ones.
// Latency: q reflects an increment one clk edge after inc.
// Backpressure: none; inc is sampled every cycle.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc, stop at the top value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: PC/IF-ID enables, flushes, bubbles, EX forwarding (FWD_EN).
// Latency: controls combinational from inputs and state; state and counters update on clk.
// Backpressure: a stall holds PC and IF/ID and injects an ID/EX bubble; redirect overrides stall.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_aw,
    input  logic             ex_regwrite,
    input  logic             ex_er,
    input  logic             ex_pcsrc,
    input  logic             ex_jump,
    input  logic [4:0]       mem_aw,
    input  logic [4:0]       wb_aw,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state;
    logic [2:0] rem;
    logic       br_take;
    logic       redirect;
    logic       hazard;
    logic       stall;

    // A new redirect is only recognised in RUN; in REDIRECT, EX holds a bubble.
    assign br_take  = (state == RUN) && (ex_pcsrc || ex_jump);
    assign redirect = br_take || (state == REDIRECT);

`ifdef FWD_EN
    // With forwarding, only a load feeding the very next instruction must wait.
    assign hazard = ex_er &&
                    ((id_use_rs && dest_hit(ex_aw, ex_regwrite, id_rs)) ||
                     (id_use_rt && dest_hit(ex_aw, ex_regwrite, id_rt)));
`else
    // Without forwarding, wait until every in-flight producer has reached WB.
    assign hazard = (id_use_rs && (dest_hit(ex_aw,  ex_regwrite,  id_rs) ||
                                   dest_hit(mem_aw, mem_regwrite, id_rs))) ||
                    (id_use_rt && (dest_hit(ex_aw,  ex_regwrite,  id_rt) ||
                                   dest_hit(mem_aw, mem_regwrite, id_rt)));

    logic unused_nofwd;
    assign unused_nofwd = ^{ex_rs, ex_rt, wb_aw, wb_regwrite, ex_er};
`endif

    assign stall = hazard && !redirect;

    // Pipeline controls: reset forces NOPs, then redirect > stall > normal flow.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst_n) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // EX operand selects: newest producer (MEM) wins over WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
`ifdef FWD_EN
        if (rst_n) begin
            if (dest_hit(mem_aw, mem_regwrite, ex_rs))     fwd_a = FWD_MEM;
            else if (dest_hit(wb_aw, wb_regwrite, ex_rs))  fwd_a = FWD_WB;
            if (dest_hit(mem_aw, mem_regwrite, ex_rt))     fwd_b = FWD_MEM;
            else if (dest_hit(wb_aw, wb_regwrite, ex_rt))  fwd_b = FWD_WB;
        end
`endif
    end

    // Redirect FSM: the triggering cycle flushes once, REDIRECT covers the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (br_take && (FLUSH_CYCLES > 1)) begin
                        state <= REDIRECT;
                        rem   <= 3'(FLUSH_CYCLES - 1);
                    end
                end
                REDIRECT: begin
                    rem <= rem - 3'd1;
                    if (rem <= 3'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    rem   <= '0;
                end
            endcase
        end
    end

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .q     (stall_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_take),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-window reference model.
// Latency: outputs checked 1 time unit after inputs settle, counters 1 unit after the edge.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_aw, mem_aw, wb_aw;
    logic          id_use_rs, id_use_rt, ex_regwrite, ex_er, ex_pcsrc, ex_jump;
    logic          mem_regwrite, wb_regwrite;
    logic          pc_we, ifid_we, ifid_flush, idex_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles of redirect window left, plus event counts.
    int left = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_aw(ex_aw),
        .ex_regwrite(ex_regwrite), .ex_er(ex_er),
        .ex_pcsrc(ex_pcsrc), .ex_jump(ex_jump),
        .mem_aw(mem_aw), .wb_aw(wb_aw),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // True when source s is read and a real writer d/we targets it.
    function automatic bit hit(input bit use_s, input logic [4:0] s,
                               input logic [4:0] d, input bit we);
        return use_s && we && (d != 0) && (s == d);
    endfunction

    function automatic bit model_hazard();
`ifdef FWD_EN
        return ex_er && (hit(id_use_rs, id_rs, ex_aw, ex_regwrite) ||
                         hit(id_use_rt, id_rt, ex_aw, ex_regwrite));
`else
        return hit(id_use_rs, id_rs, ex_aw, ex_regwrite) || hit(id_use_rs, id_rs, mem_aw, mem_regwrite) ||
               hit(id_use_rt, id_rt, ex_aw, ex_regwrite) || hit(id_use_rt, id_rt, mem_aw, mem_regwrite);
`endif
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef FWD_EN
        if (hit(1'b1, src, mem_aw, mem_regwrite)) return 2'b10;
        if (hit(1'b1, src, wb_aw, wb_regwrite))   return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic set_idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_aw = 0; ex_regwrite = 0; ex_er = 0;
        ex_pcsrc = 0; ex_jump = 0;
        mem_aw = 0; wb_aw = 0; mem_regwrite = 0; wb_regwrite = 0;
    endtask

    // One cycle: check controls for the driven inputs, clock, check counters.
    task automatic step(input string tag);
        bit r, s;
        #1;
        r = (left > 0) || ex_pcsrc || ex_jump;
        s = !r && model_hazard();
        check({tag, ".pc_we"},      {31'd0, pc_we},      {31'd0, r || !s});
        check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, r});
        check({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, r || s});
        if (!r) check({tag, ".ifid_we"}, {31'd0, ifid_we}, {31'd0, !s});
        check({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, model_fwd(ex_rs)});
        check({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, model_fwd(ex_rt)});
        @(posedge clk);
        if (left > 0) begin
            left--;
        end else if (ex_pcsrc || ex_jump) begin
            left = FC - 1;
            if (m_fcnt < CMAX) m_fcnt++;
        end else if (s) begin
            if (m_scnt < CMAX) m_scnt++;
        end
        #1;
        check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, m_scnt);
        check({tag, ".flush_cnt"}, {28'd0, flush_cnt}, m_fcnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc_we"},      {31'd0, pc_we},      0);
        check({tag, ".ifid_we"},    {31'd0, ifid_we},    0);
        check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, 1);
        check({tag, ".idex_flush"}, {31'd0, idex_flush}, 1);
        check({tag, ".fwd"},        {28'd0, fwd_a, fwd_b}, 0);
        check({tag, ".stall_cnt"},  {28'd0, stall_cnt}, 0);
        check({tag, ".flush_cnt"},  {28'd0, flush_cnt}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle flow.
        step("idle");
        check("idle.flow", {31'd0, pc_we & ifid_we}, 1);

`ifdef FWD_EN
        // Load-use: exactly one stall cycle, then the load moves to MEM.
        ex_er = 1; ex_regwrite = 1; ex_aw = 5; id_rs = 5; id_use_rs = 1;
        step("lu");
        ex_er = 0; ex_regwrite = 0; ex_aw = 0; mem_aw = 5; mem_regwrite = 1;
        #1;
        check("lu.release", {31'd0, pc_we}, 1);
        step("lu2");
        check("lu.stall_cnt", {28'd0, stall_cnt}, 1);

        // ALU forwarding priority and register-0 exclusion.
        set_idle();
        mem_aw = 8; wb_aw = 8; mem_regwrite = 1; wb_regwrite = 1; ex_rs = 8;
        #1; check("fwd.mem", {30'd0, fwd_a}, 2'b10);
        mem_regwrite = 0;
        #1; check("fwd.wb", {30'd0, fwd_a}, 2'b01);
        ex_rt = 0; mem_aw = 0; mem_regwrite = 1;
        #1; check("fwd.r0", {30'd0, fwd_b}, 2'b00);
        step("fwd");
`else
        // Stall holds while MEM still owns register 3.
        mem_aw = 3; mem_regwrite = 1; id_rt = 3; id_use_rt = 1;
        step("nf1");
        step("nf2");
        #1; check("nf.held", {31'd0, pc_we}, 0);
        mem_aw = 0;
        #1; check("nf.release", {31'd0, pc_we}, 1);
        check("nf.fwd", {28'd0, fwd_a, fwd_b}, 0);
        step("nf3");
`endif

        // Redirect: FC flushed cycles for a one-cycle branch.
        set_idle();
        ex_pcsrc = 1;
        step("br0");
        ex_pcsrc = 0;
        for (int i = 1; i < FC; i++) begin
            #1; check("br.window", {31'd0, ifid_flush & pc_we}, 1);
            step("brw");
        end
        #1; check("br.done", {31'd0, ifid_flush}, 0);
        step("br_after");

        // Jump plus load-use hazard in the same cycle: only the flush counts.
        ex_jump = 1; ex_er = 1; ex_regwrite = 1; ex_aw = 7; id_rs = 7; id_use_rs = 1;
        step("jmp_hz");
        set_idle();
        for (int i = 1; i < FC; i++) step("jmp_w");

        // Reset in the middle of a redirect window.
        ex_pcsrc = 1;
        step("br_rst");
        ex_pcsrc = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        left = 0; m_scnt = 0; m_fcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");

        // Randomized traffic over a small register set for frequent collisions.
        for (int n = 0; n < 800; n++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_aw = 5'($urandom_range(0, 3));
            ex_regwrite = 1'($urandom); ex_er = 1'($urandom);
            ex_pcsrc = ($urandom_range(0, 11) == 0);
            ex_jump  = ($urandom_range(0, 15) == 0);
            mem_aw = 5'($urandom_range(0, 3)); wb_aw = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
